// File: rtl/phy_pkg.sv
// Shared PHY constants: the COM idle symbol and the sync FSM state encoding,
// common to the RX idle stripper and the TX idle generator.
package phy_pkg;

   localparam logic [7:0] COM_SYM   = 8'hBC;

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_ALIGN  = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

endpackage

// File: rtl/rx_idle_sync.sv
// RX idle sync: locks on SYNC_COUNT consecutive COM bytes, forwards payload, strips idles,
// drops lock after LOSS_COUNT idle-less gaps. Define RX_IDLE_STATS_EN for the idle_cnt port.
module rx_idle_sync #(
   parameter logic [7:0] COM_SYM    = phy_pkg::COM_SYM,
   parameter int         SYNC_COUNT = 4,
   parameter int         LOSS_COUNT = 8
) (
   input  logic        clk4f,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic        valid_in,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic        idle_out,
   output logic        active
`ifdef RX_IDLE_STATS_EN
   ,
   output logic [15:0] idle_cnt
`endif
);

   import phy_pkg::ST_SEARCH;
   import phy_pkg::ST_ALIGN;
   import phy_pkg::ST_ACTIVE;

   localparam int COM_W  = $clog2(SYNC_COUNT + 1);
   localparam int LOSS_W = $clog2(LOSS_COUNT + 1);

   logic [1:0]        state;
   logic [COM_W-1:0]  com_cnt;
   logic [LOSS_W-1:0] loss_cnt;
   logic              is_com;
   logic              sync_done;
   logic              loss_done;

   assign is_com    = (data_in == COM_SYM);
   // Counters stop at their terminal value, so the +1 below can never wrap.
   assign sync_done = (com_cnt + COM_W'(1)) == COM_W'(SYNC_COUNT);
   assign loss_done = (loss_cnt + LOSS_W'(1)) == LOSS_W'(LOSS_COUNT);

   // NOTE: state and registered outputs use non-blocking assignments so every
   // branch sees the pre-edge values regardless of statement order.
   always_ff @(posedge clk4f or negedge reset) begin
      if (!reset) begin
         state     <= ST_SEARCH;
         com_cnt   <= '0;
         loss_cnt  <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         idle_out  <= 1'b0;
         active    <= 1'b0;
      end else begin
         // Outputs default to silent; only a valid byte in ACTIVE produces one.
         data_out  <= '0;
         valid_out <= 1'b0;
         idle_out  <= 1'b0;
         case (state)
            ST_SEARCH: begin
               if (valid_in && is_com) begin
                  com_cnt <= COM_W'(1);
                  if (SYNC_COUNT == 1) begin
                     state  <= ST_ACTIVE;
                     active <= 1'b1;
                  end else begin
                     state <= ST_ALIGN;
                  end
               end
            end
            ST_ALIGN: begin
               if (valid_in) begin
                  if (is_com) begin
                     com_cnt <= com_cnt + COM_W'(1);
                     if (sync_done) begin
                        state  <= ST_ACTIVE;
                        active <= 1'b1;
                     end
                  end else begin
                     state   <= ST_SEARCH;
                     com_cnt <= '0;
                  end
               end
            end
            ST_ACTIVE: begin
               if (valid_in) begin
                  loss_cnt <= '0;
                  if (is_com) begin
                     idle_out <= 1'b1;
                  end else begin
                     data_out  <= data_in;
                     valid_out <= 1'b1;
                  end
               end else if (loss_done) begin
                  state    <= ST_SEARCH;
                  active   <= 1'b0;
                  com_cnt  <= '0;
                  loss_cnt <= '0;
               end else begin
                  loss_cnt <= loss_cnt + LOSS_W'(1);
               end
            end
            default: begin
               state    <= ST_SEARCH;
               active   <= 1'b0;
               com_cnt  <= '0;
               loss_cnt <= '0;
            end
         endcase
      end
   end

`ifdef RX_IDLE_STATS_EN
   // Survives loss of lock on purpose: it is a link-lifetime statistic.
   always_ff @(posedge clk4f or negedge reset) begin
      if (!reset) begin
         idle_cnt <= '0;
      end else if ((state == ST_ACTIVE) && valid_in && is_com && (idle_cnt != 16'hFFFF)) begin
         idle_cnt <= idle_cnt + 16'd1;
      end
   end
`endif

endmodule
